alu_arbiter: RTL and testbench

Shares one combinational 16-bit ALU (op 00=add, 01=sub, 10=and, 11=or; data out o, carry out cout) between two requesters. Each requester issues an operation with a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, captures the result and returns it with the winning requester's id over a valid/ready response channel. It sits between the two issuing units (e.g. address-gen and accumulate sequencers) and the single ALU instance.

---
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered before the ALU. The result returns on a valid/ready response channel.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_i0,
    output logic [WIDTH-1:0] alu_i1,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a request; grant is evaluated here only
    // EXEC  | operand registers drive the ALU; its result is captured at the end of the cycle
    // RESP  | response is held stable until the consumer takes it
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic grant_vld;
    logic grant_id;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld && grant_id;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    op_d         = grant_id ? req1_op : req0_op;
                    a_d          = grant_id ? req1_a  : req0_a;
                    b_d          = grant_id ? req1_b  : req0_b;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_o;
                rsp_cout_d  = alu_cout;
                rsp_zero_d  = (alu_o == '0);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_i0    = a_q;
    assign alu_i1    = b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: it models the ALU, pushes the expected response on each accept
// and pops it when the response handshake completes.
module tb_alu_arbiter;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_i0, alu_i1, alu_o, rsp_data;
    logic         alu_cout, rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero, busy;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
        .alu_o(alu_o), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy)
    );

    // ALU model: carry-out for subtract means that no borrow occurred.
    logic [W:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case (alu_op)
            2'b00: alu_sum = {1'b0, alu_i0} + {1'b0, alu_i1};
            2'b01: alu_sum = {1'b0, alu_i0} + {1'b0, ~alu_i1} + 17'd1;
            2'b10: alu_sum = {1'b0, alu_i0 & alu_i1};
            default: alu_sum = {1'b0, alu_i0 | alu_i1};
        endcase
    end
    assign alu_o    = alu_sum[W-1:0];
    assign alu_cout = alu_sum[W];

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         cout;
        logic         zero;
    } exp_t;

    exp_t sb_q[$];
    logic acc_ids[$];
    int   tests = 0;
    int   fails = 0;
    int   acc_cnt = 0;
    int   lat = 0;
    logic tb_last = 1'b1;
    logic [1:0]   exp_op = '0;
    logic [W-1:0] exp_a = '0, exp_b = '0;
    logic         have_prev = 1'b0;
    logic [W+3:0] prev_rsp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic id, input logic [1:0] op,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int unsigned s;
        e.id = id;
        e.cout = 1'b0;
        case (op)
            2'b00: begin
                s = int'(a) + int'(b);
                e.data = W'(s % 65536);
                e.cout = (s > 65535);
            end
            2'b01: begin
                e.data = W'((int'(a) - int'(b) + 65536) % 65536);
                e.cout = (a >= b);
            end
            2'b10: e.data = a & b;
            default: e.data = a | b;
        endcase
        e.zero = (e.data == 0);
        return e;
    endfunction

    // Monitor: every check is made on the falling edge, so inputs are stable for the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            lat = 0;
            tb_last = 1'b1;
            exp_op = '0; exp_a = '0; exp_b = '0;
            have_prev = 1'b0;
        end else begin
            if (lat > 0) begin
                lat--;
                check(lat == 1 ? "latency_exec" : "latency_resp", rsp_valid, (lat == 0));
            end
            check("ready_exclusive", req0_ready & req1_ready, 0);
            if (!busy)
                check("grant", {req1_ready, req0_ready},
                      {req1_valid && (!req0_valid || !tb_last),
                       req0_valid && (!req1_valid || tb_last)});
            else
                check("ready_when_busy", {req1_ready, req0_ready}, 0);
            check("alu_operands", {alu_op, alu_i0, alu_i1}, {exp_op, exp_a, exp_b});
            if (have_prev)
                check("rsp_hold", {rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero}, prev_rsp);
            have_prev = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zero};
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_cout", rsp_cout, e.cout);
                    check("rsp_zero", rsp_zero, e.zero);
                end
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                logic id;
                id = req1_valid && req1_ready;
                exp_op = id ? req1_op : req0_op;
                exp_a  = id ? req1_a  : req0_a;
                exp_b  = id ? req1_b  : req0_b;
                sb_q.push_back(ref_model(id, exp_op, exp_a, exp_b));
                acc_ids.push_back(id);
                tb_last = id;
                lat = 2;
                acc_cnt++;
            end
        end
    end

    task automatic check_reset(input string name);
        check({name, "_rsp_valid"}, rsp_valid, 0);
        check({name, "_rsp_fields"}, {rsp_id, rsp_data, rsp_cout, rsp_zero}, 0);
        check({name, "_alu"}, {alu_op, alu_i0, alu_i1}, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int waited);
        waited = 0;
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            waited++;
            @(posedge clk); #1;
        end
        check("issue_accepted", (waited < 20), 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) break;
            n++;
        end
        check("drain_timeout", (n < 40), 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int w;
        int acc0;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1;
        rst = 1'b0;

        issue(1'b0, 2'b00, 16'h1234, 16'h0001, w);
        check("first_ready_immediate", w, 0);
        wait_idle();

        issue(1'b1, 2'b01, 16'h0005, 16'h0005, w);
        wait_idle();

        // Both requesters held valid: expect four accepts alternating 0,1,0,1.
        acc_ids.delete();
        acc0 = acc_cnt;
        req0_valid = 1; req0_op = 2'b00; req0_a = 16'h0101; req0_b = 16'h0202;
        req1_valid = 1; req1_op = 2'b11; req1_a = 16'h00F0; req1_b = 16'h0F00;
        repeat (12) @(posedge clk);
        #1;
        req0_valid = 0; req1_valid = 0;
        check("rr_accept_count", acc_cnt - acc0, 4);
        if (acc_ids.size() == 4)
            check("rr_order", {acc_ids[0], acc_ids[1], acc_ids[2], acc_ids[3]}, 4'b0101);
        else
            check("rr_order_len", acc_ids.size(), 4);
        wait_idle();

        // Backpressure with wrap-around result; a waiting requester must not be accepted.
        rsp_ready = 1'b0;
        issue(1'b0, 2'b00, 16'hFFFF, 16'h0001, w);
        req1_valid = 1; req1_op = 2'b10; req1_a = 16'h1111; req1_b = 16'h2222;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_valid_busy", {rsp_valid, busy, rsp_data}, {1'b1, 1'b1, 16'h0000});
        @(posedge clk); #1;
        req1_valid = 0;
        rsp_ready = 1'b1;
        wait_idle();

        issue(1'b0, 2'b10, 16'hF0F0, 16'hFF00, w);
        wait_idle();
        issue(1'b1, 2'b11, 16'hF0F0, 16'hFF00, w);
        wait_idle();

        // Reset while the operation is in EXEC: no response, then tie goes to requester 0.
        issue(1'b1, 2'b00, 16'h4444, 16'h1111, w);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("rst_exec");
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1; req0_op = 2'b01; req0_a = 16'h0009; req0_b = 16'h0003;
        req1_valid = 1; req1_op = 2'b00; req1_a = 16'h0001; req1_b = 16'h0001;
        @(negedge clk);
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_idle();

        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op = 2'($urandom); req0_a = rnd_val(); req0_b = rnd_val();
            req1_op = 2'($urandom); req1_a = rnd_val(); req1_b = rnd_val();
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1'b1;
        wait_idle();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
